// File: rtl/intf_rr_arbiter.sv
// Round-robin arbiter for one shared resource, with a bounded grant tenure.
// A lock input can extend a tenure beyond MAX_HOLD.
module intf_rr_arbiter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic            release_i,
    input  logic            lock,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
    logic [IDXW-1:0]  last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             sel_found;
    logic [IDXW-1:0]  sel_idx;
    logic             owner_done;
    logic             hold_expired;
    logic             tenure_end;

    // Search starts just after the last owner, so every requester is reached in turn.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            pos = 32'(last_q) + k;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (!sel_found && req[IDXW'(pos)]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(pos);
            end
        end
    end

    // Release and owner drop take precedence over expiry, so they suppress the timeout.
    assign owner_done   = release_i | ~(|(req & grant_q));
    assign hold_expired = (cnt_q == HoldMax) & ~lock;
    assign tenure_end   = owner_done | hold_expired;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (tenure_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d     = WIDTH'(1) << sel_idx;
                    grant_idx_d = sel_idx;
                    last_d      = sel_idx;
                    cnt_d       = 4'd1;
                end else begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    cnt_d       = '0;
                end
            end
            StGrant: begin
                if (tenure_end) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    cnt_d       = '0;
                    timeout_d   = hold_expired & ~owner_done;
                end else if (cnt_q != HoldMax) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                grant_d     = '0;
                grant_idx_d = '0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= IDXW'(WIDTH - 1);
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = |grant_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// Bench for intf_rr_arbiter: directed scenarios followed by random traffic,
// all checked against a tenure-level reference model.
module tb_intf_rr_arbiter;

    localparam int W    = 3;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] req;
    logic         release_i;
    logic         lock;
    logic [W-1:0] grant;
    logic [1:0]   grant_idx;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, how long they have held it.
    int m_owner;
    int m_last;
    int m_held;
    bit m_timeout;

    intf_rr_arbiter #(
        .WIDTH   (W),
        .MAX_HOLD(HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .release_i(release_i),
        .lock     (lock),
        .grant    (grant),
        .grant_idx(grant_idx),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = W - 1;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic rel, input logic lk);
        bit done;
        bit expire;
        if (m_owner < 0) begin
            m_timeout = 1'b0;
            if (r != '0) begin
                for (int k = 1; k <= W; k++) begin
                    int c;
                    c = (m_last + k) % W;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            done   = rel || !r[m_owner];
            expire = (m_held >= HOLD) && !lk;
            if (done || expire) begin
                m_timeout = expire && !done;
                m_owner   = -1;
                m_held    = 0;
            end else begin
                m_timeout = 1'b0;
                if (m_held < HOLD) m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] eg;
        logic [1:0]   ei;
        eg = '0;
        ei = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ei          = 2'(m_owner);
        end
        chk({tag, ".grant"}, 8'(grant), 8'(eg));
        chk({tag, ".idx"}, 8'(grant_idx), 8'(ei));
        chk({tag, ".busy"}, 8'(busy), 8'(m_owner >= 0));
        chk({tag, ".timeout"}, 8'(timeout), 8'(m_timeout));
        chk({tag, ".onehot"}, 8'($onehot0(grant)), 8'd1);
    endtask

    task automatic step(input logic [W-1:0] r, input logic rel, input logic lk,
                        input string tag);
        req       = r;
        release_i = rel;
        lock      = lk;
        @(posedge clk);
        model_edge(r, rel, lk);
        #1;
        check_model(tag);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] eg, input logic et);
        chk({tag, ".lit_grant"}, 8'(grant), 8'(eg));
        chk({tag, ".lit_timeout"}, 8'(timeout), 8'(et));
    endtask

    initial begin
        logic [W-1:0] r;
        rst_n     = 1'b0;
        req       = '0;
        release_i = 1'b0;
        lock      = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b000, 1'b0, 1'b0, "idle");
        step(3'b000, 1'b1, 1'b0, "idle_release");

        // Round-robin with release one cycle after each grant.
        step(3'b111, 1'b0, 1'b0, "rr0");  expect_out("rr0", 3'b001, 1'b0);
        step(3'b111, 1'b1, 1'b0, "rr1");  expect_out("rr1", 3'b000, 1'b0);
        step(3'b111, 1'b0, 1'b0, "rr2");  expect_out("rr2", 3'b010, 1'b0);
        step(3'b111, 1'b1, 1'b0, "rr3");  expect_out("rr3", 3'b000, 1'b0);
        step(3'b111, 1'b0, 1'b0, "rr4");  expect_out("rr4", 3'b100, 1'b0);
        step(3'b111, 1'b1, 1'b0, "rr5");  expect_out("rr5", 3'b000, 1'b0);
        step(3'b111, 1'b0, 1'b0, "rr6");  expect_out("rr6", 3'b001, 1'b0);
        step(3'b111, 1'b1, 1'b0, "rr7");  expect_out("rr7", 3'b000, 1'b0);

        // Tenure expiry after MAX_HOLD cycles, then regrant.
        for (int i = 0; i < HOLD; i++) begin
            step(3'b010, 1'b0, 1'b0, "hold");
            expect_out("hold", 3'b010, 1'b0);
        end
        step(3'b010, 1'b0, 1'b0, "expire");  expect_out("expire", 3'b000, 1'b1);
        step(3'b010, 1'b0, 1'b0, "regrant"); expect_out("regrant", 3'b010, 1'b0);
        step(3'b010, 1'b1, 1'b0, "rel_a");   expect_out("rel_a", 3'b000, 1'b0);

        // Lock keeps the grant well beyond MAX_HOLD.
        for (int i = 0; i < 11; i++) begin
            step(3'b001, 1'b0, 1'b1, "lock");
            expect_out("lock", 3'b001, 1'b0);
        end
        step(3'b001, 1'b1, 1'b0, "unlock_rel"); expect_out("unlock_rel", 3'b000, 1'b0);
        step(3'b000, 1'b0, 1'b0, "after_lock"); expect_out("after_lock", 3'b000, 1'b0);

        // Release coinciding with the final hold cycle wins over timeout.
        for (int i = 0; i < HOLD; i++) step(3'b100, 1'b0, 1'b0, "race_hold");
        step(3'b100, 1'b1, 1'b0, "race_rel");  expect_out("race_rel", 3'b000, 1'b0);
        step(3'b000, 1'b0, 1'b0, "race_post"); expect_out("race_post", 3'b000, 1'b0);

        // Asynchronous reset mid-grant.
        step(3'b100, 1'b0, 1'b0, "pre_rst"); expect_out("pre_rst", 3'b100, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b101, 1'b0, 1'b0, "post_rst"); expect_out("post_rst", 3'b001, 1'b0);
        step(3'b101, 1'b1, 1'b0, "rel_b");

        // Owner drops its request while others wait.
        step(3'b111, 1'b0, 1'b0, "drop0"); expect_out("drop0", 3'b010, 1'b0);
        step(3'b101, 1'b0, 1'b0, "drop1"); expect_out("drop1", 3'b000, 1'b0);
        step(3'b101, 1'b0, 1'b0, "drop2"); expect_out("drop2", 3'b100, 1'b0);
        step(3'b101, 1'b1, 1'b0, "drop3");

        // Random traffic; requests tend to persist so tenures can expire.
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) r = W'($urandom_range(0, 7));
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intf_rr_arbiter.md
INTF_RR_ARBITER -- requirements
Module: intf_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: number of requesters sharing one interface-array resource, legal range 1..8.
REQ-002 The block SHALL have parameter MAX_HOLD, default 4: maximum grant tenure in cycles, legal range 1..15.
REQ-003 The block SHALL have derived localparam IDXW = max(1, $clog2(WIDTH)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, WIDTH bits: bit i high = requester i wants the resource.
REQ-007 The block SHALL have port release_i, input, 1 bit: the current owner ends its tenure.
REQ-008 The block SHALL have port lock, input, 1 bit: while high during a grant, the MAX_HOLD timeout is suppressed.
REQ-009 The block SHALL have port grant, output, WIDTH bits: one-hot or zero, registered.
REQ-010 The block SHALL have port grant_idx, output, IDXW bits: index of the current owner; 0 when there is no grant.
REQ-011 The block SHALL have port busy, output, 1 bit: high exactly when grant is nonzero.
REQ-012 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a tenure is ended by MAX_HOLD.

Function
REQ-013 The block SHALL implement a two-state FSM {IDLE, GRANT}, together with a round-robin pointer last[IDXW-1:0] and a hold counter cnt[3:0].
REQ-014 In IDLE with req nonzero at a rising edge, the block SHALL select the first asserted index searching last+1, last+2, ... modulo WIDTH.
REQ-015 On that same edge, the block SHALL enter GRANT, set grant one-hot, grant_idx, busy=1, last=selected index and cnt=1.
REQ-016 Latency SHALL be 1 cycle from req sampled to grant visible.
REQ-017 In IDLE with req zero, the block SHALL stay in IDLE with all outputs 0.
REQ-018 In GRANT, the tenure SHALL end on the first edge at which any of these holds: (a) release_i=1, (b) req[owner]=0, (c) cnt==MAX_HOLD and lock=0.
REQ-019 When a tenure ends, the block SHALL go to IDLE on that edge with grant=0, grant_idx=0, busy=0.
REQ-020 A guaranteed one-cycle gap SHALL separate consecutive grants.
REQ-021 When a tenure ends by (c) only, timeout SHALL be 1 for the following cycle; otherwise timeout SHALL be 0.
REQ-022 If release_i or the owner dropping req coincides with cnt==MAX_HOLD, no timeout SHALL be signalled (release wins).
REQ-023 In GRANT without an end condition, cnt SHALL increment, saturating at MAX_HOLD.
REQ-024 While lock=1, cnt SHALL hold at MAX_HOLD and the grant SHALL persist until (a) or (b).
REQ-025 Changes on req of non-owners during GRANT SHALL have no effect until IDLE.
REQ-026 With WIDTH=1, the block SHALL use the same FSM, with grant_idx always 0.
REQ-027 Fairness: with all WIDTH requesters continuously asserting, the grant order SHALL be 0,1,...,WIDTH-1,0,... with no index granted twice before every other index has been granted once.
REQ-028 The block SHALL never assert more than one grant bit, and release_i in IDLE SHALL be ignored.

Reset
REQ-029 While rst_n=0, the block SHALL force, regardless of clk: state=IDLE, grant=0, grant_idx=0, busy=0, timeout=0, cnt=0, last=WIDTH-1 (so index 0 has first priority).
REQ-030 A reset asserted mid-grant SHALL drop the grant immediately and discard the tenure without a timeout pulse.
REQ-031 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge at which rst_n=1 and req is nonzero.

Verification
REQ-032 The bench SHALL verify: WIDTH=3, req=3'b111 held, release_i pulsed one cycle after each grant -> grant sequence 001,000,010,000,100,000,001.
REQ-033 The bench SHALL verify: MAX_HOLD=4, req=3'b010 held, lock=0, no release -> grant=010 for exactly 4 cycles, then grant=000 with timeout=1 for one cycle, then regrant of 010.
REQ-034 The bench SHALL verify: lock=1 during a grant held 10 cycles -> no timeout; after lock=0 and release_i=1 the grant drops and timeout stays 0.
REQ-035 The bench SHALL verify: release_i=1 on the same edge as cnt==MAX_HOLD -> grant drops and timeout stays 0.
REQ-036 The bench SHALL verify: rst_n pulled low mid-grant on requester 2 -> grant=000 asynchronously; after release with req=3'b101, requester 0 is granted first.
REQ-037 The bench SHALL verify: owner deasserts its req while others request -> IDLE for one cycle, then the next index in round-robin order is granted.
